// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: pipeline hazard controller with a one-entry fetch buffer.
// Resolves data-cache stalls, branch/jump redirects, load-use hazards and
// instruction-cache misses into PC/stage load enables and bubble inserts.
// Optional feature macro: HAZARD_PERF_CNT_EN enables the saturating
// stall/flush/load-use performance counters; otherwise they are tied to zero.
module hazard_ctrl_unit #(
    parameter int NUM_STAGES  = 5,
    parameter int REG_W       = 5,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  imem_resp,
    input  logic                  dmem_read,
    input  logic                  dmem_write,
    input  logic                  dmem_resp,
    input  logic                  redirect,
    input  logic [REG_W-1:0]      id_rs1,
    input  logic [REG_W-1:0]      id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_W-1:0]      ex_rd,
    input  logic                  ex_mem_read,
    output logic                  inst_read,
    output logic                  load_pc,
    output logic [NUM_STAGES-2:0] load_stage,
    output logic [NUM_STAGES-2:0] rst_stage,
    output logic                  ibuf_load,
    output logic                  ibuf_sel,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [CNT_W-1:0]      lu_cnt
);

    localparam int P = NUM_STAGES - 1;

    // Stage-vector constants: bit 0 is IF/ID, bit P-1 is MEM/WB.
    localparam logic [P-1:0] ONE_BIT    = {{(P-1){1'b0}}, 1'b1};
    localparam logic [P-1:0] IDEX_BIT   = ONE_BIT << 1;
    localparam logic [P-1:0] MEMWB_BIT  = {1'b1, {(P-1){1'b0}}};
    localparam logic [P-1:0] FLUSH_MASK = ~({P{1'b1}} << FLUSH_DEPTH);
    localparam logic [P-1:0] FLUSH_BIT  = ONE_BIT << FLUSH_DEPTH;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_IHELD = 1'b1;

    logic [0:0]   state_r;
    logic [0:0]   state_nxt_s;
    logic         fetch_ok_s;
    logic         dstall_s;
    logic         lu_s;
    logic         load_pc_s;
    logic [P-1:0] load_stage_s;
    logic [P-1:0] rst_stage_s;
    logic         flush_s;
    logic         lu_hit_s;
    logic         ibuf_load_s;
    logic         ibuf_sel_s;

    assign fetch_ok_s = imem_resp | (state_r == ST_IHELD);
    assign dstall_s   = (dmem_read | dmem_write) & ~dmem_resp;
    assign lu_s       = ex_mem_read & (ex_rd != {REG_W{1'b0}}) &
                        ((id_rs1_used & (id_rs1 == ex_rd)) |
                         (id_rs2_used & (id_rs2 == ex_rd)));

    // Prioritised hazard resolution: dstall > redirect > load-use > fetch miss.
    always_comb begin
        load_pc_s    = 1'b1;
        load_stage_s = {P{1'b1}};
        rst_stage_s  = {P{1'b0}};
        flush_s      = 1'b0;
        lu_hit_s     = 1'b0;
        if (dstall_s) begin
            // Freeze the front end, let the memory op drain with a bubble behind it.
            load_pc_s    = 1'b0;
            load_stage_s = MEMWB_BIT;
            rst_stage_s  = MEMWB_BIT;
        end else if (redirect && fetch_ok_s) begin
            // Target fetch available: squash the wrong-path registers.
            rst_stage_s = FLUSH_MASK;
            flush_s     = 1'b1;
        end else if (redirect) begin
            // Target not yet fetched: hold the branch and bubble behind it.
            load_pc_s    = 1'b0;
            load_stage_s = ~FLUSH_MASK;
            rst_stage_s  = FLUSH_BIT;
        end else if (lu_s) begin
            load_pc_s    = 1'b0;
            load_stage_s = ~ONE_BIT;
            rst_stage_s  = IDEX_BIT;
            lu_hit_s     = 1'b1;
        end else if (!fetch_ok_s) begin
            load_pc_s   = 1'b0;
            rst_stage_s = ONE_BIT;
        end else begin
            load_pc_s = 1'b1;
        end
    end

    assign ibuf_load_s = (state_r == ST_RUN) & imem_resp & ~load_pc_s;
    assign ibuf_sel_s  = (state_r == ST_IHELD) & load_stage_s[0] & ~rst_stage_s[0];

    assign inst_read  = (state_r == ST_RUN);
    assign load_pc    = load_pc_s;
    assign load_stage = load_stage_s;
    assign rst_stage  = rst_stage_s;
    assign ibuf_load  = ibuf_load_s;
    assign ibuf_sel   = ibuf_sel_s;

    // Fetch-buffer state: fill when a word arrives but PC is held, drain on PC advance.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (ibuf_load_s) begin
                    state_nxt_s = ST_IHELD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_IHELD: begin
                if (load_pc_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IHELD;
                end
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // FSM state register; reset discards any buffered word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;
    logic [CNT_W-1:0] lu_cnt_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}})) begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            sat_inc = v;
        end
    endfunction

    // Saturating event counters for stalls, redirect flushes and load-use bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
            lu_cnt_r    <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_r <= sat_inc(stall_cnt_r, ~load_pc_s);
            flush_cnt_r <= sat_inc(flush_cnt_r, flush_s);
            lu_cnt_r    <= sat_inc(lu_cnt_r, lu_hit_s);
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
    assign lu_cnt    = lu_cnt_r;
`else
    logic unused_s;
    assign unused_s  = flush_s ^ lu_hit_s;
    assign stall_cnt = {CNT_W{1'b0}};
    assign flush_cnt = {CNT_W{1'b0}};
    assign lu_cnt    = {CNT_W{1'b0}};
`endif

endmodule
